// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding, instruction field codes and latency helper for the sequencer
package cpu_seq_pkg;
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_DISPATCH = 4'd3,
      S_EXT      = 4'd4,
      S_MEMRD    = 4'd5,
      S_OPLD     = 4'd6,
      S_EXEC     = 4'd7,
      S_WB       = 4'd8,
      S_NEXT     = 4'd9,
      S_JUMP     = 4'd10,
      S_HALT     = 4'd11,
      S_TRAP     = 4'd12
   } state_t;
   localparam logic [1:0] OT_MOVE    = 2'b00;
   localparam logic [1:0] OT_ARITH   = 2'b01;
   localparam logic [1:0] OT_LOGIC   = 2'b10;
   localparam logic [1:0] OT_ILL     = 2'b11;
   localparam logic [1:0] MODE_REG   = 2'b00;
   localparam logic [1:0] MODE_IMM   = 2'b01;
   localparam logic [1:0] MODE_DIR   = 2'b10;
   localparam logic [1:0] MODE_ILL   = 2'b11;
   localparam logic [1:0] BYTE_TWO   = 2'd2;
   localparam logic [3:0] OPC_HLT    = 4'hE;
   localparam logic [3:0] OPC_JMP    = 4'hF;
   function automatic int lat_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/seq_wait_cnt.sv
// seq_wait_cnt: loadable down-counter that sticks at zero and flags completion
module seq_wait_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_cnt,
   output logic         o_done
);
   logic [W-1:0] r_cnt;
   // reload on every state change, otherwise count down and hold at zero
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
   assign o_cnt  = r_cnt;
   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle Moore sequencer driving datapath strobes for the 16-bit CPU
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int ROM_LAT = 1,
   parameter int RAM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] ins_byte,
   input  logic [1:0] ins_mode,
   input  logic [1:0] ins_ot,
   input  logic [3:0] ins_opcode,
   output logic       ins_load,
   output logic       ext_load,
   output logic       ram_rd,
   output logic       op1_load,
   output logic       op2_load,
   output logic       alu_en,
   output logic       reg_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       busy,
   output logic       halted,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);
   localparam int CW = $clog2(lat_max(ROM_LAT, RAM_LAT) + 1);
   // timed states count down from (duration - 1) to zero
   localparam logic [CW-1:0] C_FETCH = CW'(ROM_LAT - 1);
   localparam logic [CW-1:0] C_EXT   = CW'(ROM_LAT);
   localparam logic [CW-1:0] C_MEM   = CW'(RAM_LAT - 1);
   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   w_cnt;
   logic [CW-1:0]   w_ld_val;
   logic            w_done;
   logic            w_chg;
   logic            w_illegal;
   logic            w_hlt;
   logic            w_jmp;
   assign w_illegal = (ins_ot == OT_ILL) || (ins_mode == MODE_ILL);
   assign w_hlt     = (ins_ot == OT_MOVE) && (ins_opcode == OPC_HLT);
   assign w_jmp     = (ins_ot == OT_MOVE) && (ins_opcode == OPC_JMP);
   assign w_chg     = (w_next != r_state);
   assign w_ld_val  = (w_next == S_FETCH) ? C_FETCH :
                      (w_next == S_EXT)   ? C_EXT   :
                      (w_next == S_MEMRD) ? C_MEM   : '0;
   seq_wait_cnt #(.W(CW)) u_wait (
      .clk   (clk),
      .rst   (rst),
      .i_load(w_chg),
      .i_val (w_ld_val),
      .o_cnt (w_cnt),
      .o_done(w_done)
   );
   // state register; async reset aborts any instruction in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   // next-state: walk the instruction phases, HALT and TRAP absorb
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = en ? S_FETCH : S_IDLE;
         S_FETCH:    w_next = w_done ? S_DECODE : S_FETCH;
         S_DECODE:   w_next = S_DISPATCH;
         S_DISPATCH: w_next = w_illegal ? S_TRAP :
                              w_hlt ? S_HALT :
                              w_jmp ? S_JUMP :
                              (ins_byte == BYTE_TWO) ? S_EXT : S_OPLD;
         S_EXT:      w_next = !w_done ? S_EXT : (ins_mode == MODE_DIR) ? S_MEMRD : S_OPLD;
         S_MEMRD:    w_next = w_done ? S_OPLD : S_MEMRD;
         S_OPLD:     w_next = S_EXEC;
         S_EXEC:     w_next = S_WB;
         S_WB:       w_next = S_NEXT;
         S_NEXT,
         S_JUMP:     w_next = en ? S_FETCH : S_IDLE;
         default:    w_next = r_state;
      endcase
   end
   assign ins_load   = (r_state == S_DECODE);
   assign ext_load   = (r_state == S_EXT) && w_done;
   assign ram_rd     = (r_state == S_MEMRD);
   assign op1_load   = (r_state == S_OPLD);
   assign op2_load   = (r_state == S_OPLD);
   assign alu_en     = (r_state == S_EXEC);
   assign reg_load   = (r_state == S_WB);
   assign pc_inc     = (r_state == S_NEXT) || ((r_state == S_EXT) && (w_cnt == C_EXT));
   assign pc_load    = (r_state == S_JUMP);
   assign busy       = !((r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_TRAP));
   assign halted     = (r_state == S_HALT);
   assign illegal_op = (r_state == S_TRAP);
   assign state_dbg  = r_state;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed cycle-by-cycle strobe checks for the instruction sequencer
module tb_cpu_sequencer;
   import cpu_seq_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [1:0] ins_byte = 2'd1;
   logic [1:0] ins_mode = 2'd0;
   logic [1:0] ins_ot = 2'd1;
   logic [3:0] ins_opcode = 4'd0;
   logic       ins_load, ext_load, ram_rd, op1_load, op2_load, alu_en, reg_load;
   logic       pc_inc, pc_load, busy, halted, illegal_op;
   logic [3:0] state_dbg;
   int         checks = 0;
   int         errors = 0;
   int         n_pci = 0;
   int         n_ram = 0;
   localparam logic [10:0] NONE = 11'b00000000000;
   localparam logic [10:0] INS  = 11'b10000000000;
   localparam logic [10:0] EXT  = 11'b01000000000;
   localparam logic [10:0] RAM  = 11'b00100000000;
   localparam logic [10:0] OPS  = 11'b00011000000;
   localparam logic [10:0] ALU  = 11'b00000100000;
   localparam logic [10:0] REG  = 11'b00000010000;
   localparam logic [10:0] PCI  = 11'b00000001000;
   localparam logic [10:0] PCL  = 11'b00000000100;
   localparam logic [10:0] HLT  = 11'b00000000010;
   localparam logic [10:0] ILL  = 11'b00000000001;
   logic [10:0] w_str;
   assign w_str = {ins_load, ext_load, ram_rd, op1_load, op2_load, alu_en, reg_load,
                   pc_inc, pc_load, halted, illegal_op};
   cpu_sequencer #(.ROM_LAT(1), .RAM_LAT(3)) dut (
      .clk(clk), .rst(rst), .en(en),
      .ins_byte(ins_byte), .ins_mode(ins_mode), .ins_ot(ins_ot), .ins_opcode(ins_opcode),
      .ins_load(ins_load), .ext_load(ext_load), .ram_rd(ram_rd),
      .op1_load(op1_load), .op2_load(op2_load), .alu_en(alu_en), .reg_load(reg_load),
      .pc_inc(pc_inc), .pc_load(pc_load), .busy(busy), .halted(halted),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // one clock, then compare {busy, state, strobes} against the hand-derived value
   task automatic cyc(input string tag, input state_t st, input logic [10:0] s, input logic b);
      step();
      n_pci += int'(pc_inc);
      n_ram += int'(ram_rd);
      chk(tag, 32'({busy, state_dbg, w_str}), 32'({b, st, s}));
   endtask
   task automatic set_ins(input logic [1:0] b, input logic [1:0] m, input logic [1:0] o,
                          input logic [3:0] op);
      ins_byte = b;
      ins_mode = m;
      ins_ot = o;
      ins_opcode = op;
   endtask
   task automatic do_reset(input string tag);
      rst = 1'b1;
      step();
      chk(tag, 32'({busy, state_dbg, w_str}), 32'd0);
      rst = 1'b0;
      n_pci = 0;
      n_ram = 0;
   endtask
   initial begin
      // reg-mode ADD, 7-cycle instruction then straight back into FETCH
      set_ins(2'd1, MODE_REG, OT_ARITH, 4'h0);
      do_reset("rst_add");
      cyc("add_fetch", S_FETCH, NONE, 1'b1);
      cyc("add_dec", S_DECODE, INS, 1'b1);
      cyc("add_disp", S_DISPATCH, NONE, 1'b1);
      cyc("add_opld", S_OPLD, OPS, 1'b1);
      cyc("add_exec", S_EXEC, ALU, 1'b1);
      cyc("add_wb", S_WB, REG, 1'b1);
      cyc("add_next", S_NEXT, PCI, 1'b1);
      cyc("add_fetch2", S_FETCH, NONE, 1'b1);
      // direct 2-word with RAM_LAT=3
      set_ins(2'd2, MODE_DIR, OT_ARITH, 4'h3);
      do_reset("rst_dir");
      cyc("dir_fetch", S_FETCH, NONE, 1'b1);
      cyc("dir_dec", S_DECODE, INS, 1'b1);
      cyc("dir_disp", S_DISPATCH, NONE, 1'b1);
      cyc("dir_ext0", S_EXT, PCI, 1'b1);
      cyc("dir_ext1", S_EXT, EXT, 1'b1);
      for (int i = 0; i < 3; i++) cyc("dir_mem", S_MEMRD, RAM, 1'b1);
      cyc("dir_opld", S_OPLD, OPS, 1'b1);
      cyc("dir_exec", S_EXEC, ALU, 1'b1);
      cyc("dir_wb", S_WB, REG, 1'b1);
      cyc("dir_next", S_NEXT, PCI, 1'b1);
      chk("dir_pc_inc_count", 32'(n_pci), 32'd2);
      chk("dir_ram_rd_count", 32'(n_ram), 32'd3);
      cyc("dir_fetch2", S_FETCH, NONE, 1'b1);
      // immediate 2-word skips MEMRD
      set_ins(2'd2, MODE_IMM, OT_LOGIC, 4'h1);
      do_reset("rst_imm");
      cyc("imm_fetch", S_FETCH, NONE, 1'b1);
      cyc("imm_dec", S_DECODE, INS, 1'b1);
      cyc("imm_disp", S_DISPATCH, NONE, 1'b1);
      cyc("imm_ext0", S_EXT, PCI, 1'b1);
      cyc("imm_ext1", S_EXT, EXT, 1'b1);
      cyc("imm_opld", S_OPLD, OPS, 1'b1);
      cyc("imm_exec", S_EXEC, ALU, 1'b1);
      cyc("imm_wb", S_WB, REG, 1'b1);
      cyc("imm_next", S_NEXT, PCI, 1'b1);
      // JMP: pc_load in cycle 4, no ALU or register write
      set_ins(2'd1, MODE_REG, OT_MOVE, OPC_JMP);
      do_reset("rst_jmp");
      cyc("jmp_fetch", S_FETCH, NONE, 1'b1);
      cyc("jmp_dec", S_DECODE, INS, 1'b1);
      cyc("jmp_disp", S_DISPATCH, NONE, 1'b1);
      cyc("jmp_jump", S_JUMP, PCL, 1'b1);
      cyc("jmp_fetch2", S_FETCH, NONE, 1'b1);
      // illegal ot traps and stays silent
      set_ins(2'd1, MODE_REG, OT_ILL, 4'h0);
      do_reset("rst_trap");
      cyc("trap_fetch", S_FETCH, NONE, 1'b1);
      cyc("trap_dec", S_DECODE, INS, 1'b1);
      cyc("trap_disp", S_DISPATCH, NONE, 1'b1);
      for (int i = 0; i < 21; i++) cyc("trap_hold", S_TRAP, ILL, 1'b0);
      do_reset("trap_clear");
      // illegal mode outranks HLT opcode
      set_ins(2'd1, MODE_ILL, OT_MOVE, OPC_HLT);
      cyc("prio_fetch", S_FETCH, NONE, 1'b1);
      cyc("prio_dec", S_DECODE, INS, 1'b1);
      cyc("prio_disp", S_DISPATCH, NONE, 1'b1);
      cyc("prio_trap", S_TRAP, ILL, 1'b0);
      // HLT absorbs with en held high
      set_ins(2'd1, MODE_REG, OT_MOVE, OPC_HLT);
      do_reset("rst_hlt");
      cyc("hlt_fetch", S_FETCH, NONE, 1'b1);
      cyc("hlt_dec", S_DECODE, INS, 1'b1);
      cyc("hlt_disp", S_DISPATCH, NONE, 1'b1);
      for (int i = 0; i < 21; i++) cyc("hlt_hold", S_HALT, HLT, 1'b0);
      do_reset("hlt_clear");
      // en dropped during EXEC: instruction completes, then parks in IDLE
      set_ins(2'd1, MODE_REG, OT_ARITH, 4'h0);
      do_reset("rst_en");
      cyc("en_fetch", S_FETCH, NONE, 1'b1);
      cyc("en_dec", S_DECODE, INS, 1'b1);
      cyc("en_disp", S_DISPATCH, NONE, 1'b1);
      cyc("en_opld", S_OPLD, OPS, 1'b1);
      cyc("en_exec", S_EXEC, ALU, 1'b1);
      en = 1'b0;
      cyc("en_wb", S_WB, REG, 1'b1);
      cyc("en_next", S_NEXT, PCI, 1'b1);
      cyc("en_idle0", S_IDLE, NONE, 1'b0);
      cyc("en_idle1", S_IDLE, NONE, 1'b0);
      en = 1'b1;
      cyc("en_refetch", S_FETCH, NONE, 1'b1);
      // async reset in the middle of MEMRD
      set_ins(2'd2, MODE_DIR, OT_ARITH, 4'h0);
      do_reset("rst_async");
      cyc("ar_fetch", S_FETCH, NONE, 1'b1);
      cyc("ar_dec", S_DECODE, INS, 1'b1);
      cyc("ar_disp", S_DISPATCH, NONE, 1'b1);
      cyc("ar_ext0", S_EXT, PCI, 1'b1);
      cyc("ar_ext1", S_EXT, EXT, 1'b1);
      cyc("ar_mem0", S_MEMRD, RAM, 1'b1);
      cyc("ar_mem1", S_MEMRD, RAM, 1'b1);
      rst = 1'b1;
      #1;
      chk("ar_async_zero", 32'({busy, state_dbg, w_str}), 32'd0);
      rst = 1'b0;
      cyc("ar_restart", S_FETCH, NONE, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
